decoder_stage_controller: RTL and testbench
===========================================

# decoder_stage_controller

Central sequencer driving `global_stage` into every union-find processing unit of the single-FPGA decoder array, and the consumer of their `busy` and `odd` outputs. Accepts a measurement round from the host, iterates GROW/MERGE until no odd cluster remains, issues PEELING, then presents the result to the host with a valid/ready handshake. One instance per decoder array.

## Interface
- `PE_COUNT`, 64: number of processing units reduced.
- `STAGE_WIDTH`, 3: width of the shared stage code.
- `MERGE_LATENCY`, 3: MERGE cycles during which `busy` is ignored (PE stage register, PE busy register, local OR register).
- `MAX_MERGE_CYCLES`, 64: merge watchdog limit per iteration.
- `MAX_ITERATIONS`, 16: grow/merge iteration limit.
- `ITER_WIDTH`, 8: width of `iteration_count`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `measurements_valid` in 1: host has a round on the measurement bus.
- `measurements_ready` out 1: controller accepts a round (IDLE only).
- `busy_pe` in PE_COUNT: per-PE `busy`.
- `odd_pe` in PE_COUNT: per-PE `odd`.
- `global_stage` out STAGE_WIDTH: stage broadcast to all PEs, registered.
- `result_valid` out 1: peeling complete, edge errors stable.
- `result_ready` in 1: host consumed result.
- `iteration_count` out ITER_WIDTH: grow iterations of current/last round.
- `iteration_overflow` out 1: round ended by `MAX_ITERATIONS`.
- `merge_timeout` out 1: a merge ended by `MAX_MERGE_CYCLES`.

## Operation
- Stage codes: IDLE=0, GROW=1, MERGE=2, PEELING=3, WRITE_TO_MEM=4, MEASUREMENT_LOADING=5, RESULT_VALID=6, RESET_ROOTS=7. WRITE_TO_MEM and RESET_ROOTS are never issued.
- `busy_or`, `odd_or`: registered OR-reductions of `busy_pe`, `odd_pe`.
- FSM, `global_stage` equals state code:
  - IDLE: `measurements_ready`=1. On `measurements_valid`: clear `iteration_count`, `iteration_overflow`, `merge_timeout`; go LOAD.
  - LOAD (MEASUREMENT_LOADING): held 2 cycles; host holds bus stable from handshake until exit. → GROW.
  - GROW: 1 cycle; `iteration_count` += 1 (saturating). → MERGE.
  - MERGE: cycle counter from 1. While counter ≤ `MERGE_LATENCY`, stay. Afterwards exit on first cycle `busy_or`=0, or when counter = `MAX_MERGE_CYCLES` (set `merge_timeout`, sticky). On exit: `odd_or`=1 and `iteration_count` < `MAX_ITERATIONS` → GROW; `odd_or`=1 and limit reached → set `iteration_overflow`, → PEELING; `odd_or`=0 → PEELING.
  - PEELING: held 2 cycles. → RESULT.
  - RESULT (RESULT_VALID): `result_valid`=1 until `result_valid & result_ready`; then → IDLE.
- `measurements_valid` outside IDLE ignored.

## Timing
- Reset values: `global_stage`=0, `measurements_ready`=0 (rises 1 cycle after reset release), `result_valid`=0, `iteration_count`=0, flags 0, counters 0, `busy_or`=`odd_or`=0.
- Reset asserted mid-round: immediate return to IDLE outputs; no partial result.
- Handshake → first LOAD cycle: 1 cycle. Result transfer cycle → IDLE next cycle; new round may start the cycle after.
- Minimum round, zero odd: 2 LOAD + 1 GROW + (`MERGE_LATENCY`+1) MERGE + 2 PEELING + 1 RESULT = 10 cycles with `result_ready` high.
- `iteration_count`, flags stable from RESULT until next accepted round.

## Configuration
- `DECODER_STAGE_STATS_EN`: defined → adds output `round_cycles` (16 bits): cycles from first LOAD cycle to first RESULT cycle inclusive of LOAD, excluding RESULT; saturates at 16'hFFFF; cleared on accept; reset 0. Not defined → port and counter absent; all other behaviour identical.

## Test plan
- No defects: valid at IDLE, `odd_pe`=0, `busy_pe`=0, `result_ready`=1 → stage sequence 5,5,1,2,2,2,2,3,3,6,0; `iteration_count`=1; flags 0; `round_cycles`=9 when enabled.
- Two iterations: `odd_pe[3]`=1 through first MERGE, 0 after → GROW issued twice, `iteration_count`=2, `result_valid` after second PEELING.
- Persistent busy: `busy_pe[0]`=1 constantly → each MERGE lasts exactly 64 cycles, `merge_timeout`=1.
- Persistent odd: `odd_pe[0]`=1 constantly → 16 GROWs, then PEELING, `iteration_overflow`=1, `iteration_count`=16.
- Result backpressure: `result_ready`=0 for 5 cycles → `global_stage`=6, `result_valid`=1 held 5+1 cycles; `measurements_valid` during hold ignored.
- Async reset in MERGE → same cycle `global_stage`=0, `result_valid`=0, counters 0; after release, normal round completes.

Source files
------------

// File: rtl/decoder_stage_controller.sv
// decoder_stage_controller: broadcasts the union-find stage and iterates GROW/MERGE until no odd cluster remains.
// Define DECODER_STAGE_STATS_EN to add the round_cycles latency output.
module decoder_stage_controller #(
    parameter int PE_COUNT         = 64,
    parameter int STAGE_WIDTH      = 3,
    parameter int MERGE_LATENCY    = 3,
    parameter int MAX_MERGE_CYCLES = 64,
    parameter int MAX_ITERATIONS   = 16,
    parameter int ITER_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   measurements_valid,
    output logic                   measurements_ready,
    input  logic [PE_COUNT-1:0]    busy_pe,
    input  logic [PE_COUNT-1:0]    odd_pe,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [ITER_WIDTH-1:0]  iteration_count,
    output logic                   iteration_overflow,
    output logic                   merge_timeout
`ifdef DECODER_STAGE_STATS_EN
    ,
    output logic [15:0]            round_cycles
`endif
);
    localparam int CW = $clog2(MAX_MERGE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GROW   = 3'd1,
        S_MERGE  = 3'd2,
        S_PEEL   = 3'd3,
        S_LOAD   = 3'd5,
        S_RESULT = 3'd6
    } state_t;

    state_t                state_q;
    logic                  ready_q, rvalid_q, ovf_q, tmo_q, busy_or_q, odd_or_q;
    logic [ITER_WIDTH-1:0] iter_q;
    logic [CW-1:0]         cnt_q;
    logic                  accept;

    assign accept             = state_q == S_IDLE && ready_q && measurements_valid;
    assign global_stage       = STAGE_WIDTH'(state_q);
    assign measurements_ready = ready_q;
    assign result_valid       = rvalid_q;
    assign iteration_count    = iter_q;
    assign iteration_overflow = ovf_q;
    assign merge_timeout      = tmo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            busy_or_q <= 1'b0;
            odd_or_q  <= 1'b0;
            iter_q    <= '0;
            cnt_q     <= '0;
        end else begin
            busy_or_q <= |busy_pe;
            odd_or_q  <= |odd_pe;
            case (state_q)
                S_IDLE: begin
                    ready_q <= !accept;
                    if (accept) begin
                        state_q <= S_LOAD;
                        iter_q  <= '0;
                        ovf_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q != '0) state_q <= S_GROW;
                end
                S_GROW: begin
                    if (iter_q != '1) iter_q <= iter_q + ITER_WIDTH'(1);
                    cnt_q   <= CW'(1);
                    state_q <= S_MERGE;
                end
                // busy is only trusted once the PE and OR-tree pipeline has refilled
                S_MERGE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q > CW'(MERGE_LATENCY) && (!busy_or_q || cnt_q == CW'(MAX_MERGE_CYCLES))) begin
                        tmo_q <= tmo_q | busy_or_q;
                        cnt_q <= '0;
                        if (odd_or_q && iter_q < ITER_WIDTH'(MAX_ITERATIONS)) begin
                            state_q <= S_GROW;
                        end else begin
                            state_q <= S_PEEL;
                            ovf_q   <= odd_or_q;
                        end
                    end
                end
                S_PEEL: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q != '0) begin
                        state_q  <= S_RESULT;
                        rvalid_q <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        state_q  <= S_IDLE;
                        rvalid_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef DECODER_STAGE_STATS_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else if (accept) cyc_q <= '0;
        else if (state_q inside {S_LOAD, S_GROW, S_MERGE, S_PEEL} && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
    end

    assign round_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_decoder_stage_controller.sv
// tb_decoder_stage_controller: table of rounds with a result scoreboard, plus reset and stage-trace sequences.
module tb_decoder_stage_controller;
    logic        clk = 1'b0, reset = 1'b1, measurements_valid = 1'b0, result_ready = 1'b1;
    logic [63:0] busy_pe = '0, odd_pe = '0;
    logic        measurements_ready, result_valid, iteration_overflow, merge_timeout;
    logic [2:0]  global_stage;
    logic [7:0]  iteration_count;
`ifdef DECODER_STAGE_STATS_EN
    logic [15:0] round_cycles;
`endif
    int checks = 0, failures = 0;

    typedef struct { bit busy; int k; int rr; } vec_t;
    typedef struct { int iter; bit ovf; bit tmo; int cyc; int rv_len; } exp_t;

    exp_t sb[$];
    int   trace[$];

    always #5 clk = ~clk;

    decoder_stage_controller dut (
        .clk(clk), .reset(reset),
        .measurements_valid(measurements_valid), .measurements_ready(measurements_ready),
        .busy_pe(busy_pe), .odd_pe(odd_pe), .global_stage(global_stage),
        .result_valid(result_valid), .result_ready(result_ready),
        .iteration_count(iteration_count), .iteration_overflow(iteration_overflow),
        .merge_timeout(merge_timeout)
`ifdef DECODER_STAGE_STATS_EN
        , .round_cycles(round_cycles)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // k = number of merges with an odd cluster present; busy = one PE busy throughout
    task automatic run_vec(input vec_t v);
        exp_t e, x;
        int   mlen, grows, run, cyc, rv, n;
        mlen     = v.busy ? 64 : 4;
        e.iter   = (v.k + 1 > 16) ? 16 : v.k + 1;
        e.ovf    = v.k >= 16;
        e.tmo    = v.busy;
        e.cyc    = 4 + e.iter * (1 + mlen);
        e.rv_len = v.rr + 1;
        busy_pe      = v.busy ? 64'h1 : 64'h0;
        odd_pe       = '0;
        result_ready = (v.rr == 0);
        trace.delete();
        grows = 0; run = 0; cyc = 0; rv = 0; n = 0;
        measurements_valid = 1'b1;
        while (!measurements_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", measurements_ready, 1);
        sb.push_back(e);
        @(negedge clk);
        measurements_valid = 1'b0;
        n = 0;
        while (global_stage != 3'd6 && n < 3000) begin
            trace.push_back(global_stage);
            cyc++;
            if (global_stage == 3'd1) grows++;
            if (global_stage == 3'd2) run++;
            else if (run != 0) begin
                check("merge_len", run, mlen);
                run = 0;
            end
            odd_pe[3] = grows > 0 && grows <= v.k;
            @(negedge clk);
            n++;
        end
        check("reached_result", global_stage, 6);
        check("grow_count", grows, e.iter);
        odd_pe = '0;
        measurements_valid = v.rr > 0;
        for (int i = 0; i < v.rr; i++) begin
            trace.push_back(global_stage);
            rv += int'(result_valid);
            @(negedge clk);
        end
        measurements_valid = 1'b0;
        result_ready = 1'b1;
        trace.push_back(global_stage);
        check("stage_at_transfer", global_stage, 6);
        rv += int'(result_valid);
        check("rvalid_len", rv, e.rv_len);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            x = sb.pop_front();
            check("iteration_count", iteration_count, x.iter);
            check("iteration_overflow", iteration_overflow, x.ovf);
            check("merge_timeout", merge_timeout, x.tmo);
            check("round_len", cyc, x.cyc);
`ifdef DECODER_STAGE_STATS_EN
            check("round_cycles", round_cycles, x.cyc);
`endif
        end
        @(negedge clk);
        trace.push_back(global_stage);
        check("idle_after_result", global_stage, 0);
        check("rvalid_after_result", result_valid, 0);
        check("ready_after_result", measurements_ready, 1);
        check("iter_stable", iteration_count, e.iter);
        check("tmo_stable", merge_timeout, e.tmo);
        busy_pe = '0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   exp_tr[11];
        int   n;
        exp_tr = '{5, 5, 1, 2, 2, 2, 2, 3, 3, 6, 0};
        vecs[0] = '{busy: 1'b0, k: 1,  rr: 0};
        vecs[1] = '{busy: 1'b1, k: 0,  rr: 0};
        vecs[2] = '{busy: 1'b0, k: 99, rr: 0};
        vecs[3] = '{busy: 1'b0, k: 0,  rr: 5};
        vecs[4] = '{busy: 1'b0, k: 3,  rr: 2};
        vecs[5] = '{busy: 1'b1, k: 1,  rr: 1};

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stage", global_stage, 0);
        check("rst_ready", measurements_ready, 0);
        check("rst_rvalid", result_valid, 0);
        check("rst_iter", iteration_count, 0);
        check("rst_flags", {iteration_overflow, merge_timeout}, 0);
        reset = 1'b1;
        #1 check("ready_low_at_release", measurements_ready, 0);
        @(negedge clk);
        check("ready_after_release", measurements_ready, 1);

        run_vec('{busy: 1'b0, k: 0, rr: 0});
        check("trace_len", trace.size(), 11);
        for (int i = 0; i < 11; i++)
            check($sformatf("trace[%0d]", i), (i < trace.size()) ? trace[i] : -1, exp_tr[i]);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        busy_pe = 64'h1;
        measurements_valid = 1'b1;
        n = 0;
        while (global_stage != 3'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        measurements_valid = 1'b0;
        check("reached_merge", global_stage, 2);
        check("iter_in_merge", iteration_count, 1);
        #2 reset = 1'b0;
        #1;
        check("async_stage", global_stage, 0);
        check("async_rvalid", result_valid, 0);
        check("async_iter", iteration_count, 0);
        check("async_ready", measurements_ready, 0);
        check("async_flags", {iteration_overflow, merge_timeout}, 0);
`ifdef DECODER_STAGE_STATS_EN
        check("async_round_cycles", round_cycles, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        busy_pe = '0;
        @(negedge clk);
        run_vec('{busy: 1'b0, k: 1, rr: 0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
